// File: rtl/ca_hv_gen_if.sv
// Seed and output handshake bundle for ca_hv_gen. The mode field exists only when
// CA_RULE150_EN is defined. Both channels use valid/ready: a transfer happens on a
// rising clock edge where valid and ready are both high; valid never depends on ready.
`ifndef DIM
`define DIM 1024
`endif

interface ca_hv_gen_if #(
  parameter int DIM   = `DIM,
  parameter int CNT_W = 10
);
  logic             seed_valid;
  logic             seed_ready;
  logic [DIM-1:0]   seed;
  logic [CNT_W-1:0] num_vec;
`ifdef CA_RULE150_EN
  logic             mode;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [DIM-1:0]   out_vec;
  logic [CNT_W-1:0] out_idx;
  logic             out_last;
  logic             busy;

  // master: seed source and vector consumer; slave: the generator itself
  modport master (
    output seed_valid, seed, num_vec,
`ifdef CA_RULE150_EN
    output mode,
`endif
    output out_ready,
    input  seed_ready, out_valid, out_vec, out_idx, out_last, busy
  );

  modport slave (
    input  seed_valid, seed, num_vec,
`ifdef CA_RULE150_EN
    input  mode,
`endif
    input  out_ready,
    output seed_ready, out_valid, out_vec, out_idx, out_last, busy
  );
endinterface

// File: rtl/ca_hv_gen.sv
// Cellular-automaton hypervector generator: streams rule-90 evolutions of a seed.
// Define CA_RULE150_EN to add a per-seed mode selecting rule 150 instead.
`ifndef DIM
`define DIM 1024
`endif

module ca_hv_gen #(
  parameter int DIM   = `DIM,
  parameter int CNT_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  ca_hv_gen_if.slave      bus,
  output logic            dbg_state
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [DIM-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] len_q, len_d;
`ifdef CA_RULE150_EN
  logic             mode_q, mode_d;
`endif

  logic           seed_fire;
  logic           out_fire;
  logic           is_last;
  logic [DIM-1:0] rule90;
  logic [DIM-1:0] next_vec;

  assign seed_fire = bus.seed_valid && (state_q == IDLE);
  assign out_fire  = bus.out_ready && (state_q == RUN);
  assign is_last   = (idx_q == len_q - {{(CNT_W-1){1'b0}}, 1'b1});

  // Cyclic neighbours: rotate-left puts v[i-1] at i, rotate-right puts v[i+1] at i.
  assign rule90 = {vec_q[DIM-2:0], vec_q[DIM-1]} ^ {vec_q[0], vec_q[DIM-1:1]};

`ifdef CA_RULE150_EN
  assign next_vec = mode_q ? (rule90 ^ vec_q) : rule90;
`else
  assign next_vec = rule90;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
`ifdef CA_RULE150_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
`ifdef CA_RULE150_EN
      mode_q  <= mode_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    len_d   = len_q;
`ifdef CA_RULE150_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        // A zero-length request completes its handshake but leaves the block idle.
        if (seed_fire && (bus.num_vec != '0)) begin
          state_d = RUN;
          vec_d   = bus.seed;
          idx_d   = '0;
          len_d   = bus.num_vec;
`ifdef CA_RULE150_EN
          mode_d  = bus.mode;
`endif
        end
      end
      RUN: begin
        if (out_fire) begin
          if (is_last) begin
            state_d = IDLE;
          end else begin
            vec_d = next_vec;
            idx_d = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.seed_ready = (state_q == IDLE);
    bus.out_valid  = (state_q == RUN);
    bus.busy       = (state_q == RUN);
    bus.out_vec    = vec_q;
    bus.out_idx    = idx_q;
    bus.out_last   = (state_q == RUN) && is_last;
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_ca_hv_gen.sv
// Directed bench for ca_hv_gen at DIM=8, CNT_W=4 with hand-computed vectors.
`ifndef DIM
`define DIM 1024
`endif

module tb_ca_hv_gen;

  localparam int DIM   = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  logic dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  ca_hv_gen_if #(.DIM(DIM), .CNT_W(CNT_W)) ifc ();

  ca_hv_gen #(.DIM(DIM), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: offers one seed, removes it just after the accepting edge,
  // and returns at the following negedge.
  task automatic send_seed(input logic [DIM-1:0] s, input logic [CNT_W-1:0] n, input logic m);
    ifc.seed_valid = 1'b1;
    ifc.seed       = s;
    ifc.num_vec    = n;
`ifdef CA_RULE150_EN
    ifc.mode       = m;
`else
    if (m) $display("[TB] mode ignored in rule-90 build");
`endif
    check("seed_ready_before_seed", 32'(ifc.seed_ready), 32'd1);
    @(posedge clk);
    #1;
    ifc.seed_valid = 1'b0;
    @(negedge clk);
  endtask

  // Checks one presented vector, then advances one cycle.
  task automatic expect_vec(input string tag, input logic [DIM-1:0] v,
                            input logic [CNT_W-1:0] idx, input logic last);
    check({tag, "_valid"}, 32'(ifc.out_valid), 32'd1);
    check({tag, "_vec"},   32'(ifc.out_vec),   32'(v));
    check({tag, "_idx"},   32'(ifc.out_idx),   32'(idx));
    check({tag, "_last"},  32'(ifc.out_last),  32'(last));
    @(negedge clk);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 32'(ifc.out_valid),  32'd0);
    check({tag, "_ready"}, 32'(ifc.seed_ready), 32'd1);
    check({tag, "_busy"},  32'(ifc.busy),       32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    ifc.seed_valid = 1'b0;
    ifc.seed       = '0;
    ifc.num_vec    = '0;
    ifc.out_ready  = 1'b1;
`ifdef CA_RULE150_EN
    ifc.mode       = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state
    check("rst_seed_ready", 32'(ifc.seed_ready), 32'd1);
    check("rst_out_valid",  32'(ifc.out_valid),  32'd0);
    check("rst_out_vec",    32'(ifc.out_vec),    32'd0);
    check("rst_out_idx",    32'(ifc.out_idx),    32'd0);
    check("rst_out_last",   32'(ifc.out_last),   32'd0);
    check("rst_busy",       32'(ifc.busy),       32'd0);
    check("rst_state",      32'(dbg_state),      32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic rule-90 run
    send_seed(8'h01, 4'd4, 1'b0);
    check("basic_busy", 32'(ifc.busy), 32'd1);
    expect_vec("basic0", 8'h01, 4'd0, 1'b0);
    expect_vec("basic1", 8'h82, 4'd1, 1'b0);
    expect_vec("basic2", 8'h44, 4'd2, 1'b0);
    expect_vec("basic3", 8'hAA, 4'd3, 1'b1);
    expect_idle("basic_end");

    // backpressure at idx 1
    send_seed(8'h01, 4'd4, 1'b0);
    expect_vec("bp0", 8'h01, 4'd0, 1'b0);
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) expect_vec("bp_hold", 8'h82, 4'd1, 1'b0);
    ifc.out_ready = 1'b1;
    expect_vec("bp1", 8'h82, 4'd1, 1'b0);
    expect_vec("bp2", 8'h44, 4'd2, 1'b0);
    expect_vec("bp3", 8'hAA, 4'd3, 1'b1);
    expect_idle("bp_end");

    // zero-length request
    send_seed(8'h5A, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_idle("zero");
      @(negedge clk);
    end

    // seed offered while busy is ignored
    send_seed(8'h01, 4'd4, 1'b0);
    ifc.seed_valid = 1'b1;
    ifc.seed       = 8'hFF;
    ifc.num_vec    = 4'd4;
    expect_vec("busy0", 8'h01, 4'd0, 1'b0);
    expect_vec("busy1", 8'h82, 4'd1, 1'b0);
    expect_vec("busy2", 8'h44, 4'd2, 1'b0);
    expect_vec("busy3", 8'hAA, 4'd3, 1'b1);
    expect_idle("busy_end");
    @(posedge clk);
    #1;
    ifc.seed_valid = 1'b0;
    @(negedge clk);
    expect_vec("ff0", 8'hFF, 4'd0, 1'b0);
    expect_vec("ff1", 8'h00, 4'd1, 1'b0);
    expect_vec("ff2", 8'h00, 4'd2, 1'b0);
    expect_vec("ff3", 8'h00, 4'd3, 1'b1);
    expect_idle("ff_end");

    // reset mid-run at idx 2
    send_seed(8'h01, 4'd4, 1'b0);
    expect_vec("mr0", 8'h01, 4'd0, 1'b0);
    expect_vec("mr1", 8'h82, 4'd1, 1'b0);
    check("mr2_idx", 32'(ifc.out_idx), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("mr_rst_valid", 32'(ifc.out_valid),  32'd0);
    check("mr_rst_vec",   32'(ifc.out_vec),    32'd0);
    check("mr_rst_ready", 32'(ifc.seed_ready), 32'd1);
    check("mr_rst_idx",   32'(ifc.out_idx),    32'd0);
    rst = 1'b0;
    send_seed(8'h01, 4'd2, 1'b0);
    expect_vec("rs0", 8'h01, 4'd0, 1'b0);
    expect_vec("rs1", 8'h82, 4'd1, 1'b1);
    expect_idle("rs_end");

    // all-zero seed, and a single-vector run
    send_seed(8'h00, 4'd3, 1'b0);
    expect_vec("z0", 8'h00, 4'd0, 1'b0);
    expect_vec("z1", 8'h00, 4'd1, 1'b0);
    expect_vec("z2", 8'h00, 4'd2, 1'b1);
    expect_idle("z_end");
    send_seed(8'h81, 4'd1, 1'b0);
    expect_vec("one0", 8'h81, 4'd0, 1'b1);
    expect_idle("one_end");

`ifdef CA_RULE150_EN
    send_seed(8'h01, 4'd2, 1'b1);
    expect_vec("r150_0", 8'h01, 4'd0, 1'b0);
    expect_vec("r150_1", 8'h83, 4'd1, 1'b1);
    expect_idle("r150_end");
    send_seed(8'h01, 4'd2, 1'b0);
    expect_vec("r90_0", 8'h01, 4'd0, 1'b0);
    expect_vec("r90_1", 8'h82, 4'd1, 1'b1);
    expect_idle("r90_end");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
